// File: rtl/seg_blink_driver.sv
// Eight-digit 7-segment output stage with field blinking, lamp test and display enable.
// Every digit is registered, and one shared phase counter drives the blink of all fields.

module seg_blink_lane #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] code,
    input  logic       blink,
    input  logic       phase,
    input  logic       lamp_test,
    input  logic       disp_en,
    output logic [6:0] seg
);
    localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] LIT   = ~BLANK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            seg <= BLANK;
        else if (lamp_test)
            seg <= LIT;
        else if (!disp_en)
            seg <= BLANK;
        else if (blink && phase)
            seg <= BLANK;
        else
            seg <= code;
    end
endmodule

module seg_blink_driver #(
    parameter int HALF_PERIOD = 25000000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [55:0] seg_i,
    input  logic [3:0]  blink_i,
    input  logic        hold_visible_i,
    input  logic        lamp_test_i,
    input  logic        disp_en_i,
    output logic [55:0] seg_o,
    output logic        phase_o
);
    localparam int CW = $clog2(HALF_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt;
    logic          phase;
    logic [3:0]    blink_q;
    logic          restart;

    // Any change to the blink request (set or clear) resynchronises the fields visible.
    assign restart = hold_visible_i || (blink_i != blink_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt     <= '0;
            phase   <= 1'b0;
            blink_q <= '0;
        end else begin
            blink_q <= blink_i;
            if (restart || blink_i == 4'b0000) begin
                cnt   <= '0;
                phase <= 1'b0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign phase_o = phase;

    for (genvar k = 0; k < 8; k++) begin : g_lane
        seg_blink_lane #(.ACTIVE_LOW(ACTIVE_LOW)) u_lane (
            .clk       (clk_i),
            .rst       (reset_i),
            .code      (seg_i[7*k +: 7]),
            .blink     (blink_i[k/2]),
            .phase     (phase),
            .lamp_test (lamp_test_i),
            .disp_en   (disp_en_i),
            .seg       (seg_o[7*k +: 7])
        );
    end
endmodule

// File: doc/seg_blink_driver.md
SEG_BLINK_DRIVER -- requirements
Module: seg_blink_driver

Interface
REQ-001 Parameter HALF_PERIOD, default 25000000, clk_i cycles per blink half-phase (1 Hz blink at 50 MHz); legal range 2..2^26-1.
REQ-002 Parameter ACTIVE_LOW, default 1, segment polarity of all segment inputs and outputs (1: segment lit when bit = 0).
REQ-003 clk_i  input  1  sole clock; all state on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 seg_i  input  56  eight 7-seg codes, digit k at bits [7k+6:7k]; k=0 centisec, 1 decisec, 2 sec, 3 decasec, 4 min, 5 decamin, 6 hr, 7 decahr.
REQ-006 blink_i  input  4  field blink requests: [0] lessthansec (k=0,1), [1] sec (k=2,3), [2] min (k=4,5), [3] hr (k=6,7).
REQ-007 hold_visible_i  input  1  single-cycle pulse (up/down press) forcing blinking fields visible and restarting phase.
REQ-008 lamp_test_i  input  1  level; all segments lit.
REQ-009 disp_en_i  input  1  level; 0 blanks every digit.
REQ-010 seg_o  output  56  registered segment codes to HEX displays, same digit packing as seg_i.
REQ-011 phase_o  output  1  current blink phase (0 visible, 1 blanked), registered.

Function
REQ-012 Define BLANK = 7'h7F when ACTIVE_LOW=1, 7'h00 otherwise; LIT = bitwise inverse of BLANK.
REQ-013 Phase counter SHALL count 0..HALF_PERIOD-1 every cycle; on reaching HALF_PERIOD-1 it SHALL wrap to 0 and toggle phase in the same edge.
REQ-014 Block SHALL register blink_i each cycle (blink_q) and detect change = (blink_i != blink_q).
REQ-015 Restart: when hold_visible_i=1 or change=1 in a cycle, the next edge SHALL set counter=0 and phase=0, overriding wrap/toggle in that same cycle.
REQ-016 When no blink_i bit is set, counter SHALL hold at 0 and phase at 0.
REQ-017 Per digit k, next seg_o value SHALL be, in priority order: LIT if lamp_test_i=1; BLANK if disp_en_i=0; BLANK if its field blink bit=1 and phase=1; else seg_i digit k.
REQ-018 Blanking decision SHALL use the phase value registered before the edge being evaluated and the current blink_i; latency seg_i/blink_i/lamp_test_i/disp_en_i -> seg_o is exactly 1 cycle.
REQ-019 Effect of restart on seg_o: restart cycle sees old phase; seg_o shows visible from the second edge after the restart stimulus onward.
REQ-020 Simultaneous wrap and restart: restart wins (phase=0, counter=0).
REQ-021 blink_i bit clearing counts as change (restart), so remaining blinking fields resynchronise visible.
REQ-022 Multiple blink bits set SHALL blink in unison on the single shared phase.
REQ-023 phase_o SHALL equal internal phase register.

Reset
REQ-024 While reset_i=1: seg_o=all digits BLANK, phase_o=0, counter=0, blink_q=0, regardless of clk_i.
REQ-025 Reset SHALL be asserted and removed without glitching seg_o; first post-reset edge applies REQ-017 normally.
REQ-026 Reset mid-blink SHALL discard phase; after release blinking restarts from phase 0, counter 0.

Verification (HALF_PERIOD=4, ACTIVE_LOW=1)
REQ-027 Reset asserted async mid-cycle -> seg_o=56'hFF..FF (all BLANK) immediately, phase_o=0.
REQ-028 seg_i all digits 7'h40 ("0"), blink_i=0, disp_en_i=1 -> seg_o=7'h40 every digit after 1 cycle, phase_o stays 0 indefinitely.
REQ-029 blink_i=4'b0010 held -> digits 2,3 alternate 7'h40 for 4 cycles / 7'h7F for 4 cycles (phase toggles every 4 cycles after restart), digits 0,1,4-7 constant 7'h40.
REQ-030 During blanked phase, pulse hold_visible_i one cycle -> phase_o=0 next edge, digits 2,3 show 7'h40 from second edge, next blank 4 cycles after restart.
REQ-031 lamp_test_i=1 with disp_en_i=0 and blink active -> all digits 7'h00; lamp_test_i=0, disp_en_i=0 -> all digits 7'h7F.
REQ-032 hold_visible_i coincident with counter wrap, and blink_i changing 4'b0010->4'b0100 -> phase_o=0, counter=0, digits 4,5 blink, digits 2,3 steady.
